// File: rtl/control_sequencer.sv
// Hardwired control unit for the Mini SRC bus datapath: fetch cycle plus ld, ldi, st,
// addi, in, out, nop and halt, with done-handshake waits on every memory access.
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        mem_done,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        CON_in,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zhighin,
  output logic        HIin,
  output logic        LOin,
  output logic        OutPortin,
  output logic        PCout,
  output logic        MDRout,
  output logic        ZHIout,
  output logic        ZLOout,
  output logic        HIout,
  output logic        LOout,
  output logic        Inportout,
  output logic        Cout,
  output logic        IncPC,
  output logic        read,
  output logic        write,
  output logic [4:0]  operation,
  output logic        run,
  output logic        illegal,
  output logic [3:0]  present_state
);

  typedef enum logic [3:0] {
    S_RESET = 4'b0000,
    S_T0    = 4'b0001,
    S_T1    = 4'b0010,
    S_T2    = 4'b0011,
    S_T3    = 4'b0100,
    S_T4    = 4'b0101,
    S_T5    = 4'b0110,
    S_T6    = 4'b0111,
    S_T7    = 4'b1000,
    S_HALT  = 4'b1001
  } state_e;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] ALU_ADD = 5'b00011;

  state_e     state_q;
  state_e     state_d;
  logic [4:0] opcode;
  logic       unused_ir_fields;

  assign opcode           = ir[31:27];
  assign unused_ir_fields = ^ir[26:0];
  assign present_state    = state_q;

  // state register; clear overrides any wait or in-flight instruction
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state and Moore control decode from the registered state and the opcode
  always_comb begin
    state_d   = state_q;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    BAout     = 1'b0;
    CON_in    = 1'b0;
    PCin      = 1'b0;
    IRin      = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    Yin       = 1'b0;
    Zlowin    = 1'b0;
    Zhighin   = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    OutPortin = 1'b0;
    PCout     = 1'b0;
    MDRout    = 1'b0;
    ZHIout    = 1'b0;
    ZLOout    = 1'b0;
    HIout     = 1'b0;
    LOout     = 1'b0;
    Inportout = 1'b0;
    Cout      = 1'b0;
    IncPC     = 1'b0;
    read      = 1'b0;
    write     = 1'b0;
    operation = 5'b00000;
    run       = 1'b1;
    illegal   = 1'b0;

    case (state_q)
      S_RESET: begin
        state_d = S_T0;
      end
      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zlowin  = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        ZLOout = 1'b1;
        PCin   = 1'b1;
        read   = 1'b1;
        MDRin  = 1'b1;
        if (mem_done) begin
          state_d = S_T2;
        end else begin
          state_d = S_T1;
        end
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        case (opcode)
          OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_IN, OP_OUT: state_d = S_T3;
          OP_NOP:  state_d = S_T0;
          OP_HALT: state_d = S_HALT;
          default: begin
            illegal = 1'b1;
            state_d = S_T0;
          end
        endcase
      end
      S_T3: begin
        case (opcode)
          OP_LD, OP_LDI, OP_ST: begin
            Grb     = 1'b1;
            BAout   = 1'b1;
            Yin     = 1'b1;
            state_d = S_T4;
          end
          OP_ADDI: begin
            Grb     = 1'b1;
            Rout    = 1'b1;
            Yin     = 1'b1;
            state_d = S_T4;
          end
          OP_IN: begin
            Inportout = 1'b1;
            Gra       = 1'b1;
            Rin       = 1'b1;
            state_d   = S_T0;
          end
          OP_OUT: begin
            Gra       = 1'b1;
            Rout      = 1'b1;
            OutPortin = 1'b1;
            state_d   = S_T0;
          end
          default: state_d = S_T0;
        endcase
      end
      S_T4: begin
        Cout      = 1'b1;
        operation = ALU_ADD;
        Zlowin    = 1'b1;
        state_d   = S_T5;
      end
      S_T5: begin
        case (opcode)
          OP_LD, OP_ST: begin
            ZLOout  = 1'b1;
            MARin   = 1'b1;
            state_d = S_T6;
          end
          OP_LDI, OP_ADDI: begin
            ZLOout  = 1'b1;
            Gra     = 1'b1;
            Rin     = 1'b1;
            state_d = S_T0;
          end
          default: state_d = S_T0;
        endcase
      end
      S_T6: begin
        case (opcode)
          OP_LD: begin
            read  = 1'b1;
            MDRin = 1'b1;
            if (mem_done) begin
              state_d = S_T7;
            end else begin
              state_d = S_T6;
            end
          end
          OP_ST: begin
            Gra     = 1'b1;
            Rout    = 1'b1;
            MDRin   = 1'b1;
            state_d = S_T7;
          end
          default: state_d = S_T0;
        endcase
      end
      S_T7: begin
        case (opcode)
          OP_LD: begin
            MDRout  = 1'b1;
            Gra     = 1'b1;
            Rin     = 1'b1;
            state_d = S_T0;
          end
          OP_ST: begin
            write = 1'b1;
            if (mem_done) begin
              state_d = S_T0;
            end else begin
              state_d = S_T7;
            end
          end
          default: state_d = S_T0;
        endcase
      end
      S_HALT: begin
        run     = 1'b0;
        state_d = S_HALT;
      end
      default: begin
        state_d = S_RESET;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed-vector bench for control_sequencer: each cycle's state, control word and run
// flag are compared against hand-written expectations.
module tb_control_sequencer;

  logic        clock;
  logic        clear;
  logic [31:0] ir;
  logic        mem_done;
  logic Gra, Grb, Grc, Rin, Rout, BAout, CON_in;
  logic PCin, IRin, MARin, MDRin, Yin, Zlowin, Zhighin, HIin, LOin, OutPortin;
  logic PCout, MDRout, ZHIout, ZLOout, HIout, LOout, Inportout, Cout;
  logic IncPC, read, write, run, illegal;
  logic [4:0] operation;
  logic [3:0] present_state;
  logic [33:0] ctrl;

  int vec_cnt = 0;
  int err_cnt = 0;

  localparam logic [3:0] ST_RST = 4'd0, ST_T0 = 4'd1, ST_T1 = 4'd2, ST_T2 = 4'd3,
                         ST_T3 = 4'd4, ST_T4 = 4'd5, ST_T5 = 4'd6, ST_T6 = 4'd7,
                         ST_T7 = 4'd8, ST_HALT = 4'd9;

  localparam logic [33:0] M_GRA  = 34'd1 << 33, M_GRB   = 34'd1 << 32, M_GRC  = 34'd1 << 31;
  localparam logic [33:0] M_RIN  = 34'd1 << 30, M_ROUT  = 34'd1 << 29, M_BAOUT = 34'd1 << 28;
  localparam logic [33:0] M_PCIN = 34'd1 << 26, M_IRIN  = 34'd1 << 25, M_MARIN = 34'd1 << 24;
  localparam logic [33:0] M_MDRIN = 34'd1 << 23, M_YIN  = 34'd1 << 22, M_ZLOWIN = 34'd1 << 21;
  localparam logic [33:0] M_OUTPIN = 34'd1 << 17, M_PCOUT = 34'd1 << 16, M_MDROUT = 34'd1 << 15;
  localparam logic [33:0] M_ZLOOUT = 34'd1 << 13, M_INPOUT = 34'd1 << 10, M_COUT = 34'd1 << 9;
  localparam logic [33:0] M_INCPC = 34'd1 << 8, M_READ = 34'd1 << 7, M_WRITE = 34'd1 << 6;
  localparam logic [33:0] M_OPADD = 34'd3 << 1, M_ILL = 34'd1;

  localparam logic [33:0] C_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN;
  localparam logic [33:0] C_T1 = M_ZLOOUT | M_PCIN | M_READ | M_MDRIN;
  localparam logic [33:0] C_T2 = M_MDROUT | M_IRIN;
  localparam logic [33:0] C_ADDR = M_GRB | M_BAOUT | M_YIN;
  localparam logic [33:0] C_ADD = M_COUT | M_OPADD | M_ZLOWIN;

  assign ctrl = {Gra, Grb, Grc, Rin, Rout, BAout, CON_in, PCin, IRin, MARin, MDRin, Yin,
                 Zlowin, Zhighin, HIin, LOin, OutPortin, PCout, MDRout, ZHIout, ZLOout,
                 HIout, LOout, Inportout, Cout, IncPC, read, write, operation, illegal};

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_done(mem_done),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .CON_in(CON_in), .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
    .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin), .HIin(HIin), .LOin(LOin),
    .OutPortin(OutPortin), .PCout(PCout), .MDRout(MDRout), .ZHIout(ZHIout),
    .ZLOout(ZLOout), .HIout(HIout), .LOout(LOout), .Inportout(Inportout),
    .Cout(Cout), .IncPC(IncPC), .read(read), .write(write), .operation(operation),
    .run(run), .illegal(illegal), .present_state(present_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    vec_cnt++;
    if (obs !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // one cycle: wait for the falling edge, then compare state, control word and run
  task automatic exp_cycle(input string tag, input logic [3:0] st, input logic [33:0] c,
                           input logic r);
    @(negedge clock);
    check_eq({tag, ".state"}, 40'(present_state), 40'(st));
    check_eq({tag, ".ctrl"},  40'(ctrl), 40'(c));
    check_eq({tag, ".run"},   40'(run), 40'(r));
  endtask

  // T0, T1 with nwait extra wait cycles, then T2 carrying t2_ctrl
  task automatic fetch(input string tag, input logic [31:0] ir_val, input int nwait,
                       input logic [33:0] t2_ctrl);
    exp_cycle({tag, ".T0"}, ST_T0, C_T0, 1'b1);
    ir = ir_val;
    for (int i = 0; i <= nwait; i++) begin
      exp_cycle({tag, ".T1"}, ST_T1, C_T1, 1'b1);
      mem_done = (i == nwait);
    end
    exp_cycle({tag, ".T2"}, ST_T2, t2_ctrl, 1'b1);
  endtask

  initial begin
    clear    = 1'b1;
    ir       = 32'h0090_0055;
    mem_done = 1'b1;
    exp_cycle("por0", ST_RST, 34'd0, 1'b1);
    exp_cycle("por1", ST_RST, 34'd0, 1'b1);
    clear = 1'b0;

    // ld interrupted by a two-cycle clear
    fetch("ldclr", 32'h0090_0055, 0, C_T2);
    exp_cycle("ldclr.T3", ST_T3, C_ADDR, 1'b1);
    clear = 1'b1;
    exp_cycle("clr0", ST_RST, 34'd0, 1'b1);
    exp_cycle("clr1", ST_RST, 34'd0, 1'b1);
    clear = 1'b0;

    // in R3
    fetch("in", 32'hB180_0000, 0, C_T2);
    exp_cycle("in.T3", ST_T3, M_INPOUT | M_GRA | M_RIN, 1'b1);

    // out R5 with three wait cycles in T1
    fetch("out", 32'hBA80_0000, 3, C_T2);
    exp_cycle("out.T3", ST_T3, M_GRA | M_ROUT | M_OUTPIN, 1'b1);

    // ld R1,0x55(R2) with two wait cycles in T6
    fetch("ld", 32'h0090_0055, 0, C_T2);
    exp_cycle("ld.T3", ST_T3, C_ADDR, 1'b1);
    exp_cycle("ld.T4", ST_T4, C_ADD, 1'b1);
    exp_cycle("ld.T5", ST_T5, M_ZLOOUT | M_MARIN, 1'b1);
    for (int i = 0; i <= 2; i++) begin
      exp_cycle("ld.T6", ST_T6, M_READ | M_MDRIN, 1'b1);
      mem_done = (i == 2);
    end
    exp_cycle("ld.T7", ST_T7, M_MDROUT | M_GRA | M_RIN, 1'b1);

    // addi R2,R4,-5
    fetch("addi", 32'h6127_FFFB, 0, C_T2);
    exp_cycle("addi.T3", ST_T3, M_GRB | M_ROUT | M_YIN, 1'b1);
    exp_cycle("addi.T4", ST_T4, C_ADD, 1'b1);
    exp_cycle("addi.T5", ST_T5, M_ZLOOUT | M_GRA | M_RIN, 1'b1);

    // unsupported opcode 01111
    fetch("ill", 32'h7927_FFFB, 0, C_T2 | M_ILL);

    // ldi
    fetch("ldi", 32'h0890_0055, 0, C_T2);
    exp_cycle("ldi.T3", ST_T3, C_ADDR, 1'b1);
    exp_cycle("ldi.T4", ST_T4, C_ADD, 1'b1);
    exp_cycle("ldi.T5", ST_T5, M_ZLOOUT | M_GRA | M_RIN, 1'b1);

    // st with one wait cycle in T7; mem_done low in T5/T6 must be ignored there
    fetch("st", 32'h1090_0055, 0, C_T2);
    exp_cycle("st.T3", ST_T3, C_ADDR, 1'b1);
    exp_cycle("st.T4", ST_T4, C_ADD, 1'b1);
    mem_done = 1'b0;
    exp_cycle("st.T5", ST_T5, M_ZLOOUT | M_MARIN, 1'b1);
    exp_cycle("st.T6", ST_T6, M_GRA | M_ROUT | M_MDRIN, 1'b1);
    for (int i = 0; i <= 1; i++) begin
      exp_cycle("st.T7", ST_T7, M_WRITE, 1'b1);
      mem_done = (i == 1);
    end

    // nop
    fetch("nop", 32'hD000_0000, 0, C_T2);

    // halt: parks with run low while mem_done toggles, until clear
    fetch("halt", 32'hD800_0000, 0, C_T2);
    for (int i = 0; i < 20; i++) begin
      exp_cycle("halt.H", ST_HALT, 34'd0, 1'b0);
      mem_done = ~mem_done;
    end
    clear = 1'b1;
    exp_cycle("halt.rst", ST_RST, 34'd0, 1'b1);
    clear = 1'b0;
    exp_cycle("halt.T0", ST_T0, C_T0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that drives the bus datapath's control lines for the Mini SRC fetch cycle and a decoded subset of instructions: ld, ldi, st, addi, in, out, nop, halt. It sits opposite the datapath's control-signal interface. It reads the instruction from the datapath's IR and issues the per-step select, enable, and output strobes. Memory accesses use a done-handshake, so fetch and load/store tolerate variable memory latency.

## Interface
- No parameters.
- clock  in  1  system clock; all state changes on rising edge.
- clear  in  1  synchronous, active-high reset.
- ir  in  32  current IR contents; opcode ir[31:27].
- mem_done  in  1  memory completed the current read/write; sampled on rising edge.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-file select/enable.
- CON_in  out  1  held 0 (no branches in this subset).
- PCin, IRin, MARin, MDRin, Yin, Zlowin, Zhighin, HIin, LOin, OutPortin  out  1 each  register load enables.
- PCout, MDRout, ZHIout, ZLOout, HIout, LOout, Inportout, Cout  out  1 each  bus drivers; at most one is high per cycle.
- IncPC  out  1  ALU computes PC+1.
- read, write  out  1 each  memory request; held until mem_done.
- operation  out  5  ALU op code; ADD = 00011, else 00000.
- run  out  1  0 only in HALT.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- present_state  out  4  current state, for debug.

## Operation
- Opcodes: ld 00000, ldi 00001, st 00010, addi 01100, in 10110, out 10111, nop 11010, halt 11011.
- States: RESET 0000, T0–T7 0001–1000, HALT 1001.
- Outputs are a Moore decode of the registered state and ir. Every signal not listed for a state is 0.
- RESET: all outputs 0, run=1. Next state is T0.
- T0: PCout, MARin, IncPC, Zlowin.
- T1: ZLOout, PCin, read, MDRin. Stays in T1 while mem_done=0.
- T2: MDRout, IRin.
- Leaving T2, decode the opcode:
  - nop → T0.
  - halt → HALT.
  - unsupported → T0, with illegal=1 during T2.
- ld:
  - T3 Grb, BAout, Yin.
  - T4 Cout, operation=ADD, Zlowin.
  - T5 ZLOout, MARin.
  - T6 read, MDRin; waits on mem_done.
  - T7 MDRout, Gra, Rin.
- ldi: T3 and T4 as ld; T5 ZLOout, Gra, Rin.
- st:
  - T3–T5 as ld.
  - T6 Gra, Rout, MDRin.
  - T7 write; waits on mem_done.
- addi:
  - T3 Grb, Rout, Yin.
  - T4 Cout, operation=ADD, Zlowin.
  - T5 ZLOout, Gra, Rin.
- in: T3 Inportout, Gra, Rin.
- out: T3 Gra, Rout, OutPortin.
- After an instruction's last step, next state is T0.
- HALT: all controls 0, run=0. Stays in HALT until clear.

## Timing
- One state per clock. Outputs are valid for the whole cycle and are captured by the datapath on the following rising edge.
- Wait states (T1; ld T6; st T7):
  - Leave the state on the edge where mem_done=1.
  - read/write and MDRin stay high throughout the wait.
  - mem_done outside a wait state is ignored.
- Zero-wait latency, T0 through the last step:
  - nop 3 cycles.
  - in/out 4 cycles.
  - ldi/addi 6 cycles.
  - ld/st 8 cycles.
  - Each mem_done-low cycle adds 1.
- clear has priority over everything, including mid-instruction and mid-wait. The next state is RESET and all outputs drop to 0 in the following cycle.
- ir is sampled only during T2 (the decode transition) and the states that follow. A change in ir during T0/T1 has no effect on sequencing.

## Test plan
- Reset: clear high for 2 cycles mid-ld → present_state=0000 and all controls 0. The first cycle after release shows present_state=0000; the next shows T0 with PCout=MARin=IncPC=Zlowin=1.
- in R3, ir=0xB1800000, mem_done=1 always:
  - T0–T3 in 4 cycles.
  - T3 has Inportout=Gra=Rin=1 and all other bus drivers 0.
  - Then T0.
- out R5, ir=0xBA800000, mem_done held 0 for 3 cycles in T1:
  - T1 persists 4 cycles with read=1.
  - T3 has Gra=Rout=OutPortin=1.
  - Total 7 cycles.
- ld R1,0x55(R2), ir=0x00900055:
  - T4 operation=00011 with Cout=1.
  - T6 read=1 with a 2-cycle wait.
  - T7 MDRout=Gra=Rin=1.
  - 10 cycles total.
- addi R2,R4,-5, ir=0x6127FFFB: T3 Grb=Rout=Yin=1; T5 ZLOout=Gra=Rin=1; 6 cycles. Repeat with opcode 01111 → illegal=1 in T2, then T0.
- halt, ir=0xD8000000 → HALT and run=0; stays 20 cycles with mem_done toggling. clear → RESET, then T0, run=1.
